// File: rtl/teclado_cajero_if.sv
// Keypad / ATM-controller signal bundle for the teclado_cajero front-end.
// The master side is the keypad (drives key inputs, observes strobes);
// the slave side is teclado_cajero itself.
interface teclado_cajero_if;
    logic [3:0]  TECLA;
    logic        TECLA_VALIDA;
    logic        MODO_MONTO;
    logic [3:0]  DIGITO;
    logic        DIGITO_STB;
    logic [31:0] MONTO;
    logic        MONTO_STB;
    logic        DESBORDE;

    modport master (
        output TECLA, TECLA_VALIDA, MODO_MONTO,
        input  DIGITO, DIGITO_STB, MONTO, MONTO_STB, DESBORDE
    );

    modport slave (
        input  TECLA, TECLA_VALIDA, MODO_MONTO,
        output DIGITO, DIGITO_STB, MONTO, MONTO_STB, DESBORDE
    );
endinterface

// File: rtl/teclado_cajero.sv
// Keypad front-end for the ATM controller: debounces key presses, strobes
// PIN digits, and accumulates decimal amount keystrokes into a 32-bit binary
// amount released on ENTER. All outputs are registered.
module teclado_cajero #(
    parameter int DEBOUNCE_CICLOS   = 2,  // 1..15
    parameter int MAX_DIGITOS_MONTO = 9   // 1..9, keeps acc within 32 bits
) (
    input logic              CLK,
    input logic              RESET,
    teclado_cajero_if.slave  bus
);

    localparam logic [1:0] ESPERA_SOLTAR = 2'd0;
    localparam logic [1:0] REPOSO        = 2'd1;
    localparam logic [1:0] FILTRO        = 2'd2;

    localparam logic [3:0] K_ENTER  = 4'hA;
    localparam logic [3:0] K_BORRAR = 4'hB;

    logic [1:0]  state_q, state_d;
    logic [3:0]  tecla_q, tecla_d;        // code being filtered
    logic [3:0]  cnt_q, cnt_d;            // consecutive stable samples
    logic [31:0] acc_q, acc_d;            // partial amount
    logic [3:0]  ndig_q, ndig_d;          // digits in partial amount
    logic        modo_q;                  // MODO_MONTO on the previous cycle
    logic        desborde_q, desborde_d;
    logic [3:0]  digito_q, digito_d;
    logic        digito_stb_q, digito_stb_d;
    logic [31:0] monto_q, monto_d;
    logic        monto_stb_q, monto_stb_d;

    logic        accept;
    logic [3:0]  key;
    logic        modo_cambio;
    logic [31:0] acc_base;
    logic [3:0]  ndig_base;
    logic        desborde_base;

    // Debounce FSM: decides when a press is accepted and which code it carries.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
        state_d = state_q;
        tecla_d = tecla_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        key     = tecla_q;
        case (state_q)
            ESPERA_SOLTAR: begin
                if (!bus.TECLA_VALIDA) begin
                    state_d = REPOSO;
                end
            end
            REPOSO: begin
                if (bus.TECLA_VALIDA) begin
                    tecla_d = bus.TECLA;
                    cnt_d   = 4'd1;
                    if (DEBOUNCE_CICLOS == 1) begin
                        accept  = 1'b1;
                        key     = bus.TECLA;
                        state_d = ESPERA_SOLTAR;
                    end else begin
                        state_d = FILTRO;
                    end
                end
            end
            FILTRO: begin
                if (!bus.TECLA_VALIDA) begin
                    state_d = REPOSO;
                end else if (bus.TECLA != tecla_q) begin
                    tecla_d = bus.TECLA;
                    cnt_d   = 4'd1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_d == 4'(DEBOUNCE_CICLOS)) begin
                        accept  = 1'b1;
                        state_d = ESPERA_SOLTAR;
                    end
                end
            end
            default: begin
                state_d = ESPERA_SOLTAR;
            end
        endcase
    end

    // Key action: mode-change clear first, then the accepted key acts on the result.
    always_comb begin
        modo_cambio   = bus.MODO_MONTO != modo_q;
        acc_base      = modo_cambio ? 32'd0 : acc_q;
        ndig_base     = modo_cambio ? 4'd0  : ndig_q;
        desborde_base = modo_cambio ? 1'b0  : desborde_q;

        acc_d        = acc_base;
        ndig_d       = ndig_base;
        desborde_d   = desborde_base;
        digito_d     = 4'd0;
        digito_stb_d = 1'b0;
        monto_d      = monto_q;
        monto_stb_d  = 1'b0;

        if (accept) begin
            if (!bus.MODO_MONTO) begin
                if (key <= 4'd9) begin
                    digito_d     = key;
                    digito_stb_d = 1'b1;
                end
            end else if (key <= 4'd9) begin
                if (ndig_base < 4'(MAX_DIGITOS_MONTO)) begin
                    acc_d  = (acc_base << 3) + (acc_base << 1) + {28'd0, key};
                    ndig_d = ndig_base + 4'd1;
                end else begin
                    desborde_d = 1'b1;
                end
            end else if (key == K_ENTER) begin
                if (ndig_base != 4'd0) begin
                    monto_d     = acc_base;
                    monto_stb_d = 1'b1;
                    acc_d       = 32'd0;
                    ndig_d      = 4'd0;
                    desborde_d  = 1'b0;
                end
            end else if (key == K_BORRAR) begin
                acc_d      = 32'd0;
                ndig_d     = 4'd0;
                desborde_d = 1'b0;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments here so every register samples pre-edge values.
        if (RESET) begin
            state_q      <= ESPERA_SOLTAR;
            tecla_q      <= 4'd0;
            cnt_q        <= 4'd0;
            acc_q        <= 32'd0;
            ndig_q       <= 4'd0;
            modo_q       <= 1'b0;
            desborde_q   <= 1'b0;
            digito_q     <= 4'd0;
            digito_stb_q <= 1'b0;
            monto_q      <= 32'd0;
            monto_stb_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tecla_q      <= tecla_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            ndig_q       <= ndig_d;
            modo_q       <= bus.MODO_MONTO;
            desborde_q   <= desborde_d;
            digito_q     <= digito_d;
            digito_stb_q <= digito_stb_d;
            monto_q      <= monto_d;
            monto_stb_q  <= monto_stb_d;
        end
    end

    assign bus.DIGITO     = digito_q;
    assign bus.DIGITO_STB = digito_stb_q;
    assign bus.MONTO      = monto_q;
    assign bus.MONTO_STB  = monto_stb_q;
    assign bus.DESBORDE   = desborde_q;

endmodule

// File: tb/tb_teclado_cajero.sv
// Self-checking bench for teclado_cajero: directed scenarios plus a random
// press sequence checked against a decimal-arithmetic model of the keypad.
module tb_teclado_cajero;
    localparam int DEB  = 2;
    localparam int MAXD = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    teclado_cajero_if bus();

    teclado_cajero #(
        .DEBOUNCE_CICLOS(DEB),
        .MAX_DIGITOS_MONTO(MAXD)
    ) dut (
        .CLK(clk),
        .RESET(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    // Observed strobe events and protocol violations.
    int          got_dig[$];
    logic [31:0] got_monto[$];
    int          viol = 0;

    // Reference model state.
    int          exp_dig[$];
    logic [31:0] exp_monto[$];
    longint      m_acc;
    int          m_n;
    bit          m_desb;
    logic [31:0] m_monto;
    bit          m_mode;

    always @(negedge clk) begin
        if (bus.DIGITO_STB === 1'b1) got_dig.push_back(int'(bus.DIGITO));
        else if (bus.DIGITO !== 4'd0) viol++;
        if (bus.MONTO_STB === 1'b1) got_monto.push_back(bus.MONTO);
        if (bus.DIGITO_STB === 1'b1 && bus.MONTO_STB === 1'b1) viol++;
    end

    function automatic string dq2s(input int q[$]);
        string s = "";
        foreach (q[i]) s = {s, $sformatf("%0d ", q[i])};
        return s;
    endfunction

    function automatic string mq2s(input logic [31:0] q[$]);
        string s = "";
        foreach (q[i]) s = {s, $sformatf("%0d ", q[i])};
        return s;
    endfunction

    task automatic clear_logs();
        got_dig.delete(); got_monto.delete();
        exp_dig.delete(); exp_monto.delete();
        viol = 0;
    endtask

    task automatic model_clear();
        m_acc = 0; m_n = 0; m_desb = 0;
    endtask

    task automatic model_accept(input int k);
        if (!m_mode) begin
            if (k <= 9) exp_dig.push_back(k);
        end else if (k <= 9) begin
            if (m_n < MAXD) begin
                m_acc = m_acc * 10 + k;
                m_n++;
            end else begin
                m_desb = 1;
            end
        end else if (k == 10) begin
            if (m_n > 0) begin
                m_monto = m_acc[31:0];
                exp_monto.push_back(m_monto);
                model_clear();
            end
        end else if (k == 11) begin
            model_clear();
        end
    endtask

    task automatic set_mode(input bit m);
        @(negedge clk);
        bus.MODO_MONTO = m;
        if (m != m_mode) model_clear();
        m_mode = m;
    endtask

    // One press: key held stable for 'hold' samples, then 'gap' low samples.
    task automatic press(input int k, input int hold, input int gap);
        @(negedge clk);
        bus.TECLA = 4'(k);
        bus.TECLA_VALIDA = 1'b1;
        repeat (hold) @(negedge clk);
        bus.TECLA_VALIDA = 1'b0;
        if (hold >= DEB) model_accept(k);
        repeat (gap) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.TECLA = 4'd0; bus.TECLA_VALIDA = 1'b0; bus.MODO_MONTO = 1'b0;
        m_mode = 0; m_monto = 0; model_clear();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.DIGITO_STB !== 1'b0) begin errors++; $display("FAIL reset_digito_stb got=%b exp=0", bus.DIGITO_STB); end
        checks++; if (bus.DIGITO !== 4'd0) begin errors++; $display("FAIL reset_digito got=%0d exp=0", bus.DIGITO); end
        checks++; if (bus.MONTO !== 32'd0) begin errors++; $display("FAIL reset_monto got=%0d exp=0", bus.MONTO); end
        checks++; if (bus.MONTO_STB !== 1'b0) begin errors++; $display("FAIL reset_monto_stb got=%b exp=0", bus.MONTO_STB); end
        checks++; if (bus.DESBORDE !== 1'b0) begin errors++; $display("FAIL reset_desborde got=%b exp=0", bus.DESBORDE); end
    endtask

    // Strobe must appear exactly in the cycle after edge E1+(DEB-1).
    task automatic test_latency();
        clear_logs();
        set_mode(0);
        @(negedge clk);
        bus.TECLA = 4'd6; bus.TECLA_VALIDA = 1'b1;
        for (int i = 1; i <= DEB + 2; i++) begin
            @(negedge clk);
            checks++;
            if (bus.DIGITO_STB !== (i == DEB)) begin
                errors++;
                $display("FAIL latency_cycle%0d stb got=%b exp=%b", i, bus.DIGITO_STB, (i == DEB));
            end
        end
        bus.TECLA_VALIDA = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (dq2s(got_dig) != "6 ") begin errors++; $display("FAIL latency_digits got='%s' exp='6 '", dq2s(got_dig)); end
    endtask

    task automatic test_pin();
        clear_logs();
        set_mode(0);
        press(9, 3, 2); press(5, 3, 2); press(4, 3, 2); press(7, 3, 2);
        checks++; if (dq2s(got_dig) != "9 5 4 7 ") begin errors++; $display("FAIL pin_digits got='%s' exp='9 5 4 7 '", dq2s(got_dig)); end
        checks++; if (got_monto.size() != 0) begin errors++; $display("FAIL pin_no_monto got=%0d strobes exp=0", got_monto.size()); end
        checks++; if (viol != 0) begin errors++; $display("FAIL pin_protocol got=%0d violations exp=0", viol); end
    endtask

    task automatic test_amount();
        clear_logs();
        set_mode(1);
        press(5, 3, 2); press(0, 3, 2); press(0, 3, 2); press(0, 3, 2); press(0, 3, 2);
        press(10, 3, 2);
        checks++; if (mq2s(got_monto) != "50000 ") begin errors++; $display("FAIL amount_strobes got='%s' exp='50000 '", mq2s(got_monto)); end
        checks++; if (bus.MONTO !== 32'h0000C350) begin errors++; $display("FAIL amount_value got=%h exp=0000c350", bus.MONTO); end
        press(10, 3, 4);
        checks++; if (got_monto.size() != 1) begin errors++; $display("FAIL amount_lone_enter got=%0d strobes exp=1", got_monto.size()); end
        checks++; if (bus.MONTO !== 32'h0000C350) begin errors++; $display("FAIL amount_held got=%h exp=0000c350", bus.MONTO); end
    endtask

    task automatic test_overflow();
        clear_logs();
        set_mode(1);
        repeat (9) press(9, 2, 1);
        checks++; if (bus.DESBORDE !== 1'b0) begin errors++; $display("FAIL ovf_before got=%b exp=0", bus.DESBORDE); end
        press(9, 2, 1);
        checks++; if (bus.DESBORDE !== 1'b1) begin errors++; $display("FAIL ovf_after10 got=%b exp=1", bus.DESBORDE); end
        press(10, 2, 2);
        checks++; if (bus.MONTO !== 32'h3B9AC9FF) begin errors++; $display("FAIL ovf_monto got=%0d exp=999999999", bus.MONTO); end
        checks++; if (bus.DESBORDE !== 1'b0) begin errors++; $display("FAIL ovf_cleared got=%b exp=0", bus.DESBORDE); end
    endtask

    task automatic test_debounce();
        clear_logs();
        set_mode(0);
        press(3, 1, 3);
        checks++; if (got_dig.size() != 0) begin errors++; $display("FAIL glitch got=%0d strobes exp=0", got_dig.size()); end
        @(negedge clk);
        bus.TECLA = 4'd3; bus.TECLA_VALIDA = 1'b1;
        @(negedge clk);
        bus.TECLA = 4'd8;
        @(negedge clk);
        checks++; if (bus.DIGITO_STB !== 1'b0) begin errors++; $display("FAIL change_early got=%b exp=0", bus.DIGITO_STB); end
        @(negedge clk);
        checks++; if (bus.DIGITO_STB !== 1'b1 || bus.DIGITO !== 4'd8) begin errors++; $display("FAIL change_accept got=%b/%0d exp=1/8", bus.DIGITO_STB, bus.DIGITO); end
        repeat (3) @(negedge clk);
        bus.TECLA_VALIDA = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (dq2s(got_dig) != "8 ") begin errors++; $display("FAIL change_digits got='%s' exp='8 '", dq2s(got_dig)); end
    endtask

    task automatic test_borrar_mode();
        clear_logs();
        set_mode(1);
        press(4, 2, 1); press(1, 2, 1); press(11, 2, 1); press(2, 2, 1); press(10, 2, 2);
        checks++; if (bus.MONTO !== 32'd2) begin errors++; $display("FAIL borrar_monto got=%0d exp=2", bus.MONTO); end
        press(7, 2, 1);
        set_mode(0);
        set_mode(1);
        press(3, 2, 1); press(10, 2, 2);
        checks++; if (bus.MONTO !== 32'd3) begin errors++; $display("FAIL mode_monto got=%0d exp=3", bus.MONTO); end
        checks++; if (mq2s(got_monto) != "2 3 ") begin errors++; $display("FAIL borrar_strobes got='%s' exp='2 3 '", mq2s(got_monto)); end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        set_mode(0);
        @(negedge clk);
        bus.TECLA = 4'd5; bus.TECLA_VALIDA = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_monto = 0; model_clear();
        checks++;
        if (bus.DIGITO_STB !== 1'b0 || bus.DIGITO !== 4'd0 || bus.MONTO !== 32'd0 ||
            bus.MONTO_STB !== 1'b0 || bus.DESBORDE !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs got=%b/%0d/%0d/%b/%b exp=0/0/0/0/0", bus.DIGITO_STB,
                     bus.DIGITO, bus.MONTO, bus.MONTO_STB, bus.DESBORDE);
        end
        repeat (5) @(negedge clk);
        bus.TECLA_VALIDA = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (got_dig.size() != 0) begin errors++; $display("FAIL midreset_held got=%0d strobes exp=0", got_dig.size()); end
        press(5, 3, 2);
        checks++; if (dq2s(got_dig) != "5 ") begin errors++; $display("FAIL midreset_repress got='%s' exp='5 '", dq2s(got_dig)); end
    endtask

    task automatic test_random();
        int r, k;
        clear_logs();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 99) < 15) set_mode(!m_mode);
            r = int'($urandom_range(0, 19));
            k = (r < 12) ? r % 10 : (r < 15) ? 10 : (r < 17) ? 11 : r - 5;
            press(k, int'($urandom_range(1, 4)), int'($urandom_range(1, 3)));
            checks++; if (bus.DESBORDE !== m_desb) begin errors++; $display("FAIL rand%0d_desborde got=%b exp=%b", i, bus.DESBORDE, m_desb); end
            checks++; if (bus.MONTO !== m_monto) begin errors++; $display("FAIL rand%0d_monto got=%0d exp=%0d", i, bus.MONTO, m_monto); end
        end
        checks++; if (dq2s(got_dig) != dq2s(exp_dig)) begin errors++; $display("FAIL rand_digits got='%s' exp='%s'", dq2s(got_dig), dq2s(exp_dig)); end
        checks++; if (mq2s(got_monto) != mq2s(exp_monto)) begin errors++; $display("FAIL rand_montos got='%s' exp='%s'", mq2s(got_monto), mq2s(exp_monto)); end
        checks++; if (viol != 0) begin errors++; $display("FAIL rand_protocol got=%0d violations exp=0", viol); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_pin();
        test_amount();
        test_overflow();
        test_debounce();
        test_borrar_mode();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/teclado_cajero.md
# teclado_cajero

Keypad front-end for the ATM controller. It debounces raw key presses and produces the transmit side of the controller's digit and amount protocols: `DIGITO`/`DIGITO_STB` during PIN entry, and `MONTO`/`MONTO_STB` during amount entry. In amount mode it accumulates decimal keystrokes into a 32-bit binary amount and releases it only on ENTER. It sits between the physical keypad and the ATM controller's `DIGITO`, `DIGITO_STB`, `MONTO` and `MONTO_STB` inputs.

## Interface
- `DEBOUNCE_CICLOS`, default 2: consecutive high samples of `TECLA_VALIDA`, with `TECLA` unchanged, needed to accept a press. Legal range 1..15.
- `MAX_DIGITOS_MONTO`, default 9: maximum decimal digits accepted in amount mode. Legal range 1..9, which guarantees no 32-bit overflow.
- `CLK`  in  1  single clock; all logic is on the rising edge.
- `RESET`  in  1  reset, synchronous, active-high.
- `TECLA`  in  4  key code: 0..9 are digits, 4'hA is ENTER, 4'hB is BORRAR, 4'hC..4'hF are ignored.
- `TECLA_VALIDA`  in  1  level signal, high while a key is held.
- `MODO_MONTO`  in  1  0 = PIN mode, 1 = amount mode.
- `DIGITO`  out  4  accepted PIN digit; valid only while `DIGITO_STB` is high, otherwise 0.
- `DIGITO_STB`  out  1  one-cycle strobe per accepted PIN digit.
- `MONTO`  out  32  last committed amount, binary; held between commits.
- `MONTO_STB`  out  1  one-cycle strobe when `MONTO` is updated.
- `DESBORDE`  out  1  sticky flag: an amount digit was rejected because the digit limit was reached.

## Operation
- FSM states:
  - `ESPERA_SOLTAR` (the reset state): go to `REPOSO` on the first cycle `TECLA_VALIDA` is sampled low. This means a key held through reset is never accepted.
  - `REPOSO`: when `TECLA_VALIDA` is sampled high, latch `TECLA`, set the filter counter to 1 and go to `FILTRO`. If `DEBOUNCE_CICLOS` = 1, accept immediately and go to `ESPERA_SOLTAR`.
  - `FILTRO`:
    - `TECLA_VALIDA` low: go to `REPOSO`, no action.
    - `TECLA` differs from the latched code: re-latch and restart the counter at 1.
    - Otherwise increment the counter. When it reaches `DEBOUNCE_CICLOS`, accept the key and go to `ESPERA_SOLTAR`.
- Acceptance (one action per press), using `MODO_MONTO` sampled on the accepting edge:
  - PIN mode, digit 0..9: `DIGITO` = key and `DIGITO_STB` = 1 for exactly one cycle. ENTER, BORRAR and codes C..F are ignored; nothing is strobed.
  - Amount mode, digit:
    - If count < `MAX_DIGITOS_MONTO`: acc ← acc×10 + key (computed as (acc<<3)+(acc<<1)+key, 32-bit), count++.
    - Otherwise the digit is discarded and `DESBORDE` ← 1.
  - Amount mode, ENTER:
    - If count > 0: `MONTO` ← acc, `MONTO_STB` = 1 for one cycle, then clear acc, count and `DESBORDE`.
    - If count = 0: ignored; `MONTO` and `MONTO_STB` are unchanged.
  - Amount mode, BORRAR: clear acc, count and `DESBORDE`; no strobe.
  - Codes C..F in either mode: ignored.
- Mode change: any cycle where `MODO_MONTO` differs from its value on the previous cycle clears acc, count and `DESBORDE`. `MONTO` is unaffected. If a key is accepted on the same edge, the clear takes effect first and the key then acts on the cleared state.
- Leading zeros are accepted and count toward the digit limit. For example, "0","5" gives acc = 5 and count = 2.

## Timing
- Reset (synchronous) drives:
  - `DIGITO` = 0, `DIGITO_STB` = 0, `MONTO` = 0, `MONTO_STB` = 0, `DESBORDE` = 0.
  - acc = 0, count = 0, FSM = `ESPERA_SOLTAR`.
- Reset asserted mid-filter or mid-accumulation discards the pending key and the partial amount.
- Latency: let E1 be the first edge where `TECLA_VALIDA` is sampled high in `REPOSO`. The strobe is registered on edge E1+(`DEBOUNCE_CICLOS`−1) and is high for exactly the following cycle. Default: strobe high in the cycle after E2.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Each press produces at most one strobe, however long the key is held.
- Minimum press-to-press spacing: one low sample of `TECLA_VALIDA` after acceptance, then a new filter sequence.
- `DIGITO_STB` and `MONTO_STB` are never high in the same cycle.
- `DESBORDE` rises on the edge that rejects the digit. It stays high until ENTER (with count > 0), BORRAR, a mode change, or reset.

## Test plan
- PIN entry, mode 0, presses 9,5,4,7, each held 3 cycles with 2 low cycles between → four one-cycle `DIGITO_STB` pulses carrying `DIGITO` = 9,5,4,7. `DIGITO` = 0 between pulses; no `MONTO_STB`.
- Amount, mode 1, presses 5,0,0,0,0 then ENTER → single `MONTO_STB`; `MONTO` = 32'h0000C350 (50000), held afterwards. A second ENTER alone gives no strobe.
- Overflow: 10 presses of digit 9, then ENTER → `DESBORDE` = 1 after the 10th press; `MONTO` = 999999999 (32'h3B9AC9FF); `DESBORDE` = 0 after ENTER.
- Debounce: with `DEBOUNCE_CICLOS` = 2, a 1-cycle `TECLA_VALIDA` glitch → no strobe. `TECLA` changing 3→8 mid-hold → only 8 is accepted, 2 cycles after the change.
- BORRAR and mode change: 4,1 then BORRAR then 2, ENTER → `MONTO` = 2. Entering 7, toggling mode to 0 and back to 1, then 3, ENTER → `MONTO` = 3.
- Reset mid-press: `RESET` asserted during `FILTRO` while the key stays held through reset release → no strobe until the key is released and pressed again. All outputs read 0 the cycle after reset.
